bus_share_arbiter: RTL and testbench
====================================

// Module: bus_share_arbiter
// PURPOSE
//  Shares one valid/ready memory channel between NREQ requesters (e.g. IFU = 0, LSU = 1).
//  One transaction is in flight at a time.
//  A transaction is: accept request -> present on shared channel -> route response -> release.
//  Round-robin fairness between requesters.
//  Sits between the core's fetch/load-store units and the single memory/bus port.
// PARAMETERS
//  NREQ  2   number of requesters (>=2)
//  AW    32  address width
//  DW    32  data width
// PORTS
//  clk          in   1        clock; all logic on posedge
//  rst          in   1        synchronous, active-high reset
//  req_valid    in   NREQ     per-requester request valid
//  req_ready    out  NREQ     per-requester request accept (one-hot or zero)
//  req_addr     in   NREQ*AW  packed addresses, requester i at [i*AW +: AW]
//  req_wdata    in   NREQ*DW  packed write data
//  req_wen      in   NREQ     1 = write, 0 = read
//  m_valid      out  1        shared channel request valid
//  m_ready      in   1        shared channel request ready
//  m_addr       out  AW       latched address of owner
//  m_wdata      out  DW       latched write data
//  m_wen        out  1        latched write enable
//  m_rvalid     in   1        shared channel response valid
//  m_rdata      in   DW       response data
//  m_rready     out  1        response ready, equals rsp_ready[owner] in RESP state
//  rsp_valid    out  NREQ     response valid, only the owner's bit may be set
//  rsp_data     out  DW       m_rdata broadcast to all requesters
//  rsp_ready    in   NREQ     per-requester response ready
// BEHAVIOUR
//  State machine:
//  - IDLE: if |req_valid, grant the winner from rr_arbiter.
//    Winner = first set bit scanning from last_grant+1, wrapping modulo NREQ.
//    Same cycle: req_ready[winner]=1, latch addr/wdata/wen/owner, next state REQ.
//    If no request, stay in IDLE.
//  - REQ: m_valid=1 with latched payload, held stable until m_ready.
//    On m_valid & m_ready, next state RESP.
//  - RESP: rsp_valid[owner]=m_rvalid, m_rready=rsp_ready[owner].
//    On m_rvalid & rsp_ready[owner], next state IDLE and last_grant<=owner.
//  Timing:
//  - Earliest m_valid is one cycle after acceptance.
//  - Minimum transaction is 3 cycles (accept, m handshake, response handshake).
//  Outputs:
//  - req_ready is zero outside IDLE.
//  - rsp_valid and m_rready are zero outside RESP.
//  - m_valid is zero outside REQ.
//  - Requests arriving during REQ or RESP are not accepted and wait; requesters must hold valid.
//  Fairness: with all requesters continuously valid, grants rotate 0,1,..,NREQ-1,0.
//  Reset:
//  - State = IDLE, last_grant = NREQ-1 so requester 0 wins first.
//  - All outputs 0, latched payload 0.
//  - Reset mid-transaction abandons the transaction; outputs are 0 from the cycle after the reset edge.
//  Response ordering: an m_rvalid seen in REQ (before the request handshake) is ignored.
//  Back-to-back: RESP->IDLE costs one cycle, so a new grant occurs the cycle after a response completes.
// STRUCTURE
//  Package bus_share_pkg:
//  - typedef enum logic [1:0] {ARB_IDLE, ARB_REQ, ARB_RESP} arb_state_t
//  - localparam for owner index width $clog2(NREQ)
//  Sub-module rr_arbiter (req vector + last_grant -> one-hot grant + index), combinational.
//  Top holds the state register, payload latches and output muxing.
// TESTING
//  1. Reset, then only req_valid[0]=1, addr 0x8000_0000, read:
//     req_ready[0] in cycle 0; m_valid with addr 0x8000_0000 cycle 1;
//     m_ready=1; m_rvalid with rdata 0xDEAD_BEEF -> rsp_valid[0] with that data.
//  2. Both requesters valid continuously for 4 transactions -> grant order 0,1,0,1; req_ready never 2'b11.
//  3. m_ready held low 5 cycles -> m_valid, m_addr, m_wdata and m_wen stable all 5 cycles; no new req_ready.
//  4. rsp_ready[owner]=0 while m_rvalid=1 for 3 cycles -> m_rready=0, state stays RESP, rsp_valid of the other requester stays 0.
//  5. Write from requester 1 (wen=1, wdata 0x1234_5678) -> m_wen=1 and m_wdata=0x1234_5678 on the shared channel.
//  6. rst asserted in REQ state -> next cycle m_valid=0; first grant after reset goes to requester 0.

Source files
------------

// File: rtl/bus_share_arbiter_pkg.sv
// Shared types and sizing helpers for the bus-share arbiter.
package bus_share_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_REQ  = 2'd1,
    ARB_RESP = 2'd2
  } arb_state_t;

  localparam int unsigned NREQ_DEFAULT = 2;
  localparam int unsigned OWNER_W      = (NREQ_DEFAULT > 1) ? $clog2(NREQ_DEFAULT) : 1;

  // Owner index width; a single requester still needs one bit.
  function automatic int unsigned idx_width(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bus_share_arbiter_if.sv
// Requester-side and shared-channel signals of the bus-share arbiter.
interface bus_share_arbiter_if #(
  parameter int unsigned NREQ = 2,
  parameter int unsigned AW   = 32,
  parameter int unsigned DW   = 32
);
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_wdata;
  logic [NREQ-1:0]    req_wen;
  logic               m_valid;
  logic               m_ready;
  logic [AW-1:0]      m_addr;
  logic [DW-1:0]      m_wdata;
  logic               m_wen;
  logic               m_rvalid;
  logic [DW-1:0]      m_rdata;
  logic               m_rready;
  logic [NREQ-1:0]    rsp_valid;
  logic [DW-1:0]      rsp_data;
  logic [NREQ-1:0]    rsp_ready;

  // Arbiter side.
  modport master (
    input  req_valid, req_addr, req_wdata, req_wen, m_ready, m_rvalid, m_rdata, rsp_ready,
    output req_ready, m_valid, m_addr, m_wdata, m_wen, m_rready, rsp_valid, rsp_data
  );

  // Requesters and memory side.
  modport slave (
    output req_valid, req_addr, req_wdata, req_wen, m_ready, m_rvalid, m_rdata, rsp_ready,
    input  req_ready, m_valid, m_addr, m_wdata, m_wen, m_rready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/bus_share_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first set request after last_i, wrapping.
module rr_arbiter
  import bus_share_pkg::*;
#(
  parameter int unsigned NREQ = 2,
  localparam int unsigned IW  = idx_width(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IW-1:0]   last_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [IW-1:0]   idx_o,
  output logic            valid_o
);

  int unsigned cand;

  always_comb begin
    gnt_o   = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    cand    = 0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      cand = (32'(last_i) + k) % NREQ;
      if (!valid_o && req_i[cand]) begin
        valid_o     = 1'b1;
        idx_o       = IW'(cand);
        gnt_o[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bus_share_arbiter.sv
// Shares one valid/ready memory channel among NREQ requesters, one transaction at a time,
// with round-robin grant order.
module bus_share_arbiter
  import bus_share_pkg::*;
#(
  parameter int unsigned NREQ = 2,
  parameter int unsigned AW   = 32,
  parameter int unsigned DW   = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  bus_share_arbiter_if.master  bus_io
);

  localparam int unsigned IW = idx_width(NREQ);

  arb_state_t      state_q, state_d;
  logic [IW-1:0]   last_q, last_d;
  logic [IW-1:0]   owner_q, owner_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic            wen_q, wen_d;

  logic [NREQ-1:0] gnt;
  logic [IW-1:0]   gnt_idx;
  logic            gnt_valid;

  rr_arbiter #(
    .NREQ (NREQ)
  ) u_rr_arbiter (
    .req_i   (bus_io.req_valid),
    .last_i  (last_q),
    .gnt_o   (gnt),
    .idx_o   (gnt_idx),
    .valid_o (gnt_valid)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ARB_IDLE;
      last_q  <= IW'(NREQ - 1);
      owner_q <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      wen_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      owner_q <= owner_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wen_q   <= wen_d;
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    owner_d = owner_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wen_d   = wen_q;
    unique case (state_q)
      ARB_IDLE: begin
        if (gnt_valid) begin
          state_d = ARB_REQ;
          owner_d = gnt_idx;
          addr_d  = bus_io.req_addr[gnt_idx*AW +: AW];
          wdata_d = bus_io.req_wdata[gnt_idx*DW +: DW];
          wen_d   = bus_io.req_wen[gnt_idx];
        end
      end
      ARB_REQ: begin
        if (bus_io.m_ready) state_d = ARB_RESP;
      end
      ARB_RESP: begin
        if (bus_io.m_rvalid && bus_io.rsp_ready[owner_q]) begin
          state_d = ARB_IDLE;
          last_d  = owner_q;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_comb begin
    bus_io.req_ready = '0;
    bus_io.m_valid   = 1'b0;
    bus_io.m_rready  = 1'b0;
    bus_io.rsp_valid = '0;
    unique case (state_q)
      // No acceptance while reset is held: the grant would be discarded.
      ARB_IDLE: if (!rst) bus_io.req_ready = gnt;
      ARB_REQ:  bus_io.m_valid = 1'b1;
      ARB_RESP: begin
        bus_io.rsp_valid[owner_q] = bus_io.m_rvalid;
        bus_io.m_rready           = bus_io.rsp_ready[owner_q];
      end
      default: ;
    endcase
  end

  assign bus_io.m_addr   = addr_q;
  assign bus_io.m_wdata  = wdata_q;
  assign bus_io.m_wen    = wen_q;
  assign bus_io.rsp_data = bus_io.m_rdata;

endmodule

// File: tb/tb_bus_share_arbiter.sv
// Directed scenarios plus a randomized run against a transaction-level reference model.
module tb_bus_share_arbiter;
  import bus_share_pkg::*;

  localparam int unsigned NREQ = NREQ_DEFAULT;
  localparam int unsigned AW   = 32;
  localparam int unsigned DW   = 32;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  bus_share_arbiter_if #(.NREQ(NREQ), .AW(AW), .DW(DW)) bus ();

  bus_share_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus_io (bus)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #2;
  endtask

  task automatic idle_inputs;
    bus.req_valid = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.req_wen   = '0;
    bus.m_ready   = 1'b0;
    bus.m_rvalid  = 1'b0;
    bus.m_rdata   = '0;
    bus.rsp_ready = '0;
  endtask

  task automatic do_reset;
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  function automatic int rr_pick(logic [NREQ-1:0] v, int last);
    for (int k = 1; k <= int'(NREQ); k++) begin
      int i;
      i = (last + k) % int'(NREQ);
      if (v[i]) return i;
    end
    return -1;
  endfunction

  task automatic test_reset;
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    bus.req_valid = '1;
    settle();
    checks++;
    if (bus.req_ready !== '0) begin
      errors++; $display("FAIL reset_req_ready: got %b want 0", bus.req_ready);
    end
    checks++;
    if ({bus.m_valid, bus.m_rready, bus.rsp_valid, bus.m_wen} !== '0) begin
      errors++;
      $display("FAIL reset_ctrl: got mv=%b mrr=%b rv=%b wen=%b want 0", bus.m_valid,
               bus.m_rready, bus.rsp_valid, bus.m_wen);
    end
    checks++;
    if (bus.m_addr !== '0 || bus.m_wdata !== '0) begin
      errors++; $display("FAIL reset_payload: got %h/%h want 0/0", bus.m_addr, bus.m_wdata);
    end
    rst = 1'b0;
    bus.req_valid = '0;
    tick();
  endtask

  task automatic test_single_read;
    do_reset();
    bus.req_valid = 2'b01;
    bus.req_addr[0*AW +: AW] = 32'h8000_0000;
    settle();
    checks++;
    if (bus.req_ready !== 2'b01) begin
      errors++; $display("FAIL read_accept: got %b want 01", bus.req_ready);
    end
    tick();
    bus.req_valid = '0;
    settle();
    checks++;
    if (bus.m_valid !== 1'b1 || bus.m_addr !== 32'h8000_0000 || bus.m_wen !== 1'b0) begin
      errors++;
      $display("FAIL read_present: got v=%b a=%h w=%b want 1/80000000/0", bus.m_valid,
               bus.m_addr, bus.m_wen);
    end
    bus.m_ready = 1'b1;
    tick();
    bus.m_ready   = 1'b0;
    bus.m_rvalid  = 1'b1;
    bus.m_rdata   = 32'hDEAD_BEEF;
    bus.rsp_ready = 2'b01;
    settle();
    checks++;
    if (bus.rsp_valid !== 2'b01 || bus.rsp_data !== 32'hDEAD_BEEF || bus.m_rready !== 1'b1) begin
      errors++;
      $display("FAIL read_resp: got rv=%b d=%h rr=%b want 01/deadbeef/1", bus.rsp_valid,
               bus.rsp_data, bus.m_rready);
    end
    tick();
    bus.m_rvalid = 1'b0;
    settle();
    checks++;
    if (bus.rsp_valid !== '0 || bus.m_valid !== 1'b0 || bus.m_rready !== 1'b0) begin
      errors++; $display("FAIL read_release: got rv=%b mv=%b want 0/0", bus.rsp_valid, bus.m_valid);
    end
  endtask

  task automatic test_fairness;
    logic [NREQ-1:0] exp_oh;
    do_reset();
    bus.req_valid = '1;
    bus.req_addr[0*AW +: AW] = 32'h0000_1000;
    bus.req_addr[1*AW +: AW] = 32'h0000_2000;
    for (int t = 0; t < 4; t++) begin
      exp_oh = '0;
      exp_oh[t % 2] = 1'b1;
      settle();
      checks++;
      if (bus.req_ready !== exp_oh) begin
        errors++; $display("FAIL fair_grant%0d: got %b want %b", t, bus.req_ready, exp_oh);
      end
      tick();
      bus.m_ready = 1'b1;
      settle();
      checks++;
      if (bus.req_ready !== '0 || bus.m_addr !== 32'((t % 2 + 1) * 32'h1000)) begin
        errors++;
        $display("FAIL fair_req%0d: got rdy=%b a=%h want 0/%h", t, bus.req_ready, bus.m_addr,
                 32'((t % 2 + 1) * 32'h1000));
      end
      tick();
      bus.m_ready   = 1'b0;
      bus.m_rvalid  = 1'b1;
      bus.rsp_ready = '1;
      settle();
      checks++;
      if (bus.rsp_valid !== exp_oh || bus.req_ready !== '0) begin
        errors++;
        $display("FAIL fair_resp%0d: got rv=%b rdy=%b want %b/0", t, bus.rsp_valid,
                 bus.req_ready, exp_oh);
      end
      tick();
      bus.m_rvalid  = 1'b0;
      bus.rsp_ready = '0;
    end
    bus.req_valid = '0;
  endtask

  task automatic test_m_stall;
    do_reset();
    bus.req_valid = 2'b10;
    bus.req_addr[1*AW +: AW]  = 32'h1000_0040;
    bus.req_wdata[1*DW +: DW] = 32'hCAFE_0001;
    bus.req_wen[1] = 1'b1;
    settle();
    checks++;
    if (bus.req_ready !== 2'b10) begin
      errors++; $display("FAIL stall_accept: got %b want 10", bus.req_ready);
    end
    tick();
    bus.req_valid = 2'b01;
    bus.req_addr[1*AW +: AW]  = 32'hFFFF_FFFF;
    bus.req_wdata[1*DW +: DW] = 32'h0;
    bus.req_wen[1] = 1'b0;
    bus.m_rvalid  = 1'b1;
    bus.rsp_ready = '1;
    for (int c = 0; c < 5; c++) begin
      settle();
      checks++;
      if (bus.m_valid !== 1'b1 || bus.m_addr !== 32'h1000_0040 ||
          bus.m_wdata !== 32'hCAFE_0001 || bus.m_wen !== 1'b1) begin
        errors++;
        $display("FAIL stall_hold%0d: got v=%b a=%h d=%h w=%b want 1/10000040/cafe0001/1", c,
                 bus.m_valid, bus.m_addr, bus.m_wdata, bus.m_wen);
      end
      checks++;
      if (bus.req_ready !== '0 || bus.rsp_valid !== '0) begin
        errors++;
        $display("FAIL stall_quiet%0d: got rdy=%b rv=%b want 0/0", c, bus.req_ready,
                 bus.rsp_valid);
      end
      tick();
    end
    bus.m_rvalid = 1'b0;
    bus.m_ready  = 1'b1;
    tick();
    bus.m_ready  = 1'b0;
    bus.m_rvalid = 1'b1;
    tick();
    bus.m_rvalid = 1'b0;
    settle();
    checks++;
    if (bus.req_ready !== 2'b01) begin
      errors++; $display("FAIL stall_next: got %b want 01", bus.req_ready);
    end
    bus.rsp_ready = '0;
  endtask

  task automatic test_rsp_stall;
    do_reset();
    bus.req_valid = 2'b01;
    settle();
    tick();
    bus.req_valid = 2'b10;
    bus.m_ready   = 1'b1;
    tick();
    bus.m_ready   = 1'b0;
    bus.m_rvalid  = 1'b1;
    bus.m_rdata   = 32'h55AA_55AA;
    bus.rsp_ready = 2'b10;
    for (int c = 0; c < 3; c++) begin
      settle();
      checks++;
      if (bus.m_rready !== 1'b0 || bus.rsp_valid !== 2'b01) begin
        errors++;
        $display("FAIL rspstall%0d: got rr=%b rv=%b want 0/01", c, bus.m_rready, bus.rsp_valid);
      end
      checks++;
      if (bus.req_ready !== '0 || bus.m_valid !== 1'b0) begin
        errors++;
        $display("FAIL rspstall_quiet%0d: got rdy=%b mv=%b want 0/0", c, bus.req_ready,
                 bus.m_valid);
      end
      tick();
    end
    bus.rsp_ready = 2'b01;
    settle();
    checks++;
    if (bus.m_rready !== 1'b1 || bus.rsp_data !== 32'h55AA_55AA) begin
      errors++;
      $display("FAIL rspstall_done: got rr=%b d=%h want 1/55aa55aa", bus.m_rready, bus.rsp_data);
    end
    tick();
    bus.m_rvalid = 1'b0;
    settle();
    checks++;
    if (bus.req_ready !== 2'b10) begin
      errors++; $display("FAIL rspstall_next: got %b want 10", bus.req_ready);
    end
  endtask

  task automatic test_write;
    do_reset();
    bus.req_valid = 2'b10;
    bus.req_wen[1] = 1'b1;
    bus.req_wdata[1*DW +: DW] = 32'h1234_5678;
    bus.req_addr[1*AW +: AW]  = 32'h2000_0000;
    settle();
    tick();
    bus.req_valid = '0;
    settle();
    checks++;
    if (bus.m_valid !== 1'b1 || bus.m_wen !== 1'b1 || bus.m_wdata !== 32'h1234_5678 ||
        bus.m_addr !== 32'h2000_0000) begin
      errors++;
      $display("FAIL write_present: got v=%b w=%b d=%h a=%h want 1/1/12345678/20000000",
               bus.m_valid, bus.m_wen, bus.m_wdata, bus.m_addr);
    end
  endtask

  task automatic test_reset_mid;
    do_reset();
    bus.req_valid = 2'b01;
    tick();
    bus.req_valid = 2'b10;
    tick();
    bus.req_valid = '0;
    settle();
    checks++;
    if (bus.m_valid !== 1'b1) begin
      errors++; $display("FAIL midrst_pre: got %b want 1", bus.m_valid);
    end
    rst = 1'b1;
    tick();
    settle();
    checks++;
    if (bus.m_valid !== 1'b0 || bus.m_addr !== '0 || bus.req_ready !== '0) begin
      errors++;
      $display("FAIL midrst_out: got v=%b a=%h rdy=%b want 0/0/0", bus.m_valid, bus.m_addr,
               bus.req_ready);
    end
    rst = 1'b0;
    bus.req_valid = '1;
    settle();
    checks++;
    if (bus.req_ready !== 2'b01) begin
      errors++; $display("FAIL midrst_first: got %b want 01", bus.req_ready);
    end
    bus.req_valid = '0;
  endtask

  task automatic test_random;
    logic [NREQ-1:0] hold;
    logic [AW-1:0]   exp_addr;
    logic [DW-1:0]   exp_wdata;
    logic            exp_wen;
    logic [NREQ-1:0] exp_rdy, exp_rv;
    logic            exp_mv, exp_rr;
    logic            in_flight, issued;
    int              last, owner, w;
    do_reset();
    hold = '0; last = int'(NREQ) - 1; owner = 0;
    in_flight = 1'b0; issued = 1'b0;
    exp_addr = '0; exp_wdata = '0; exp_wen = 1'b0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      for (int i = 0; i < int'(NREQ); i++) begin
        if (!hold[i] && $urandom_range(0, 2) == 0) begin
          hold[i] = 1'b1;
          bus.req_addr[i*AW +: AW]  = $urandom;
          bus.req_wdata[i*DW +: DW] = $urandom;
          bus.req_wen[i] = 1'($urandom_range(0, 1));
        end
      end
      bus.req_valid = hold;
      bus.m_ready   = 1'($urandom_range(0, 1));
      bus.m_rvalid  = 1'($urandom_range(0, 1));
      bus.m_rdata   = $urandom;
      bus.rsp_ready = NREQ'($urandom);
      settle();
      exp_rdy = '0; exp_rv = '0; exp_mv = 1'b0; exp_rr = 1'b0; w = -1;
      if (!in_flight) begin
        w = rr_pick(hold, last);
        if (w >= 0) exp_rdy[w] = 1'b1;
      end else if (!issued) begin
        exp_mv = 1'b1;
      end else begin
        exp_rv[owner] = bus.m_rvalid;
        exp_rr = bus.rsp_ready[owner];
      end
      checks++;
      if (bus.req_ready !== exp_rdy || bus.m_valid !== exp_mv || bus.rsp_valid !== exp_rv ||
          bus.m_rready !== exp_rr) begin
        errors++;
        $display("FAIL rand_ctrl@%0d: got rdy=%b mv=%b rv=%b rr=%b want %b/%b/%b/%b", cyc,
                 bus.req_ready, bus.m_valid, bus.rsp_valid, bus.m_rready, exp_rdy, exp_mv,
                 exp_rv, exp_rr);
      end
      checks++;
      if (exp_mv && (bus.m_addr !== exp_addr || bus.m_wdata !== exp_wdata ||
          bus.m_wen !== exp_wen)) begin
        errors++;
        $display("FAIL rand_payload@%0d: got %h/%h/%b want %h/%h/%b", cyc, bus.m_addr,
                 bus.m_wdata, bus.m_wen, exp_addr, exp_wdata, exp_wen);
      end
      checks++;
      if (bus.rsp_data !== bus.m_rdata) begin
        errors++;
        $display("FAIL rand_rdata@%0d: got %h want %h", cyc, bus.rsp_data, bus.m_rdata);
      end
      if (!in_flight) begin
        if (w >= 0) begin
          in_flight = 1'b1; issued = 1'b0; owner = w; hold[w] = 1'b0;
          exp_addr  = bus.req_addr[w*AW +: AW];
          exp_wdata = bus.req_wdata[w*DW +: DW];
          exp_wen   = bus.req_wen[w];
        end
      end else if (!issued) begin
        if (bus.m_ready) issued = 1'b1;
      end else if (bus.m_rvalid && bus.rsp_ready[owner]) begin
        in_flight = 1'b0; issued = 1'b0; last = owner;
      end
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_single_read();
    test_fairness();
    test_m_stall();
    test_rsp_stall();
    test_write();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
